onchip_read_master_stream: RTL and testbench
============================================

ONCHIP_READ_MASTER_STREAM -- requirements
Module: onchip_read_master_stream

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W, 16, read data width, multiple of 8
  ADDR_W, 11, word address width
  LEN_W, 12, transfer length width in words
  MAX_PEND, 4, max outstanding Avalon reads, power of 2
  FIFO_DEPTH, 8, output FIFO depth in words, power of 2, >= MAX_PEND
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when both high
  cmd_addr  in  ADDR_W  start word address
  cmd_len  in  LEN_W  number of words
  cmd_stride  in  ADDR_W  address increment per word
  avm_address  out  ADDR_W  Avalon read address
  avm_read  out  1  Avalon read strobe
  avm_chipselect  out  1  Avalon chipselect, equals avm_read
  avm_byteenable  out  DATA_W/8  constant all-ones
  avm_waitrequest  in  1  slave stall
  avm_readdata  in  DATA_W  read data
  avm_readdatavalid  in  1  read data valid
  out_data  out  DATA_W  word to PE array
  out_valid  out  1  out_data valid
  out_ready  in  1  PE array accepts word
  out_last  out  1  final word of command, qualified by out_valid
  busy  out  1  command in progress
  done  out  1  one-cycle pulse at command completion
  err  out  1  sticky: readdatavalid with zero reads pending

Function
REQ-003 FSM SHALL have states IDLE, ISSUE, DRAIN; cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in ISSUE and DRAIN.
REQ-004 On cmd handshake with cmd_len>0: latch addr/len/stride, go to ISSUE; avm_read SHALL first assert in the next cycle.
REQ-005 On cmd handshake with cmd_len=0: stay IDLE, no Avalon reads, done SHALL pulse the next cycle.
REQ-006 Word i address SHALL be cmd_addr + i*cmd_stride modulo 2^ADDR_W (wrap, no error).
REQ-007 A read is accepted when avm_read=1 and avm_waitrequest=0; avm_address and avm_read SHALL stay stable while waitrequest=1.
REQ-008 avm_read SHALL assert only while pending < MAX_PEND and pending + fifo_count < FIFO_DEPTH (credit rule; FIFO never overflows).
REQ-009 Back-to-back accepted reads SHALL be possible, one per cycle, when credits allow.
REQ-010 After the cmd_len-th read is accepted: avm_read deasserts the same edge, state goes DRAIN.
REQ-011 pending SHALL increment on accept, decrement on readdatavalid; both in one cycle leave it unchanged.
REQ-012 Every avm_readdatavalid with pending>0 SHALL push avm_readdata into the FIFO in arrival order.
REQ-013 avm_readdatavalid with pending=0 SHALL be dropped and set err until reset.
REQ-014 out_valid SHALL equal FIFO non-empty; pop on out_valid and out_ready; simultaneous push and pop SHALL keep count unchanged, including at full and at empty (push to empty FIFO visible at out_valid the next cycle, no fall-through).
REQ-015 out_last SHALL be 1 for the cmd_len-th word delivered.
REQ-016 In DRAIN, the cycle after the last word handshakes on the output: go IDLE, done pulses 1 cycle.
REQ-017 out_data SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-018 While rst_n=0 at a clk edge: state IDLE, pending=0, FIFO empty, word counters 0, err=0; outputs cmd_ready=1, avm_read=0, avm_chipselect=0, avm_address=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
REQ-019 Reset mid-command SHALL abandon it; responses to reads issued before reset SHALL be dropped without setting err only if arriving while rst_n=0.

Verification
REQ-020 addr=0x010, len=4, stride=1, waitrequest=0, 1-cycle read latency, out_ready=1 -> addresses 0x010..0x013 on consecutive cycles, 4 words in order, out_last on word 4, done one cycle later.
REQ-021 addr=0x7FE, len=4, stride=1 -> addresses 0x7FE, 0x7FF, 0x000, 0x001; err stays 0.
REQ-022 len=16, out_ready=0 throughout -> exactly 8 reads accepted, FIFO full, no further avm_read; raise out_ready -> remaining 8 reads issue, 16 words delivered.
REQ-023 waitrequest high 3 cycles on 2nd read, read latency 6, MAX_PEND=4 -> address held stable during stall, never more than 4 outstanding, data order preserved.
REQ-024 len=0 -> no avm_read, done pulse next cycle; spurious readdatavalid in IDLE -> err=1, held until rst_n=0.
REQ-025 rst_n low for 1 cycle during ISSUE of len=10 -> all outputs at REQ-018 values, new cmd len=2 completes normally.

Source files
------------

// File: rtl/onchip_read_master_stream.sv
// Streaming read master: walks a strided address sequence over Avalon-MM, keeps at most
// MAX_PEND reads in flight and forwards returned words in order through a credit-sized FIFO.
module onchip_read_master_stream #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int LEN_W      = 12,
  parameter int MAX_PEND   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [ADDR_W-1:0]   cmd_stride,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_chipselect,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, stride_q;
  logic [LEN_W-1:0]  len_q, issued_q, delivered_q;
  logic [PW-1:0]     pend_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              err_q, done_q;

  logic              accept, push, pop, credit_ok, last_word;
  logic [SW-1:0]     credit_sum;

  // Every outstanding read owns a FIFO slot, so the FIFO can never overflow.
  assign credit_sum = SW'(pend_q) + SW'(count_q);
  assign credit_ok  = (pend_q < PW'(MAX_PEND)) && (credit_sum < SW'(FIFO_DEPTH));

  assign avm_read       = (state_q == StIssue) && credit_ok;
  assign avm_chipselect = avm_read;
  assign avm_address    = addr_q;
  assign avm_byteenable = '1;
  assign accept         = avm_read && !avm_waitrequest;
  assign push           = avm_readdatavalid && (pend_q != '0);

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign last_word = (delivered_q == len_q - LEN_W'(1));
  assign out_last  = out_valid && (state_q != StIdle) && last_word;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      pend_q      <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (avm_readdatavalid && (pend_q == '0)) err_q <= 1'b1;
      if (push) begin
        mem_q[wptr_q] <= avm_readdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q      <= rptr_q + AW'(1);
        delivered_q <= delivered_q + LEN_W'(1);
      end
      pend_q  <= pend_q + PW'(accept) - PW'(push);
      count_q <= count_q + CW'(push) - CW'(pop);

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= cmd_addr;
              len_q       <= cmd_len;
              stride_q    <= cmd_stride;
              issued_q    <= '0;
              delivered_q <= '0;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          if (accept) begin
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + LEN_W'(1);
            if (issued_q == len_q - LEN_W'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && out_last) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_read_master_stream.sv
// Directed bench: a latency/stall-configurable Avalon slave model plus per-scenario tasks
// that compare the recorded bus and stream activity against hand-derived expectations.
module tb_onchip_read_master_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_addr = '0;
  logic [11:0] cmd_len = '0;
  logic [10:0] cmd_stride = '0;
  logic [10:0] avm_address;
  logic        avm_read, avm_chipselect;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last, busy, done, err;

  onchip_read_master_stream dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .avm_address(avm_address), .avm_read(avm_read), .avm_chipselect(avm_chipselect),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Slave model and stream monitor state
  int          cyc = 0;
  int          lat = 1;
  logic        ready_en = 1'b0;
  logic        spur_req = 1'b0;
  int          stall_idx = -1;
  int          stall_len = 0;
  int          stall_left = 0;
  logic        stall_done = 1'b0;
  logic        stall_seen = 1'b0;
  logic        prev_stall_read = 1'b0;
  logic [10:0] prev_addr = '0;
  int          stable_bad = 0;
  int          outstanding = 0;
  int          max_out = 0;
  int          acc_count = 0;
  int          resp_due[$];
  logic [15:0] resp_dat[$];
  logic [10:0] acc_addrs[$];
  int          acc_cyc[$];
  logic [15:0] got_data[$];
  logic        got_last[$];
  int          got_cyc[$];
  int          done_cyc[$];

  function automatic logic [15:0] fdat(input logic [10:0] a);
    return {a, 5'b10101};
  endfunction

  // Inputs are driven mid-cycle; the slave shares the master's reset and forgets in-flight reads.
  always @(negedge clk) begin
    int os_start;
    cyc++;
    avm_readdatavalid = 1'b0;
    if (!rst_n) begin
      resp_due.delete();
      resp_dat.delete();
      outstanding     = 0;
      stall_left      = 0;
      avm_waitrequest = 1'b0;
      prev_stall_read = 1'b0;
    end else begin
      os_start = outstanding;
      if (spur_req) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 16'hDEAD;
        spur_req          = 1'b0;
      end else if (resp_due.size() > 0 && resp_due[0] == cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = resp_dat.pop_front();
        void'(resp_due.pop_front());
        outstanding--;
      end
      if (prev_stall_read && (!avm_read || avm_address !== prev_addr)) stable_bad++;
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else if (avm_read && !stall_done && acc_count == stall_idx) begin
        avm_waitrequest = 1'b1;
        stall_left      = stall_len - 1;
        stall_done      = 1'b1;
        stall_seen      = 1'b1;
      end else begin
        avm_waitrequest = 1'b0;
      end
      prev_stall_read = avm_waitrequest && avm_read;
      prev_addr       = avm_address;
      if (avm_read && !avm_waitrequest) begin
        if (os_start + 1 > max_out) max_out = os_start + 1;
        acc_addrs.push_back(avm_address);
        acc_cyc.push_back(cyc);
        resp_due.push_back(cyc + lat);
        resp_dat.push_back(fdat(avm_address));
        outstanding++;
        acc_count++;
      end
    end
    out_ready = ready_en;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
      got_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    acc_addrs.delete(); acc_cyc.delete(); got_data.delete(); got_last.delete();
    got_cyc.delete(); done_cyc.delete();
    acc_count = 0; max_out = 0; stable_bad = 0; stall_seen = 1'b0; stall_done = 1'b0;
    stall_idx = -1; stall_len = 0;
  endtask

  task automatic issue(input logic [10:0] a, input logic [11:0] l, input logic [10:0] s,
                       output int hcyc);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_stride = s;
    @(posedge clk);
    hcyc = cyc;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++;
      $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    vectors++; if ({avm_read, avm_chipselect} !== 2'b00) begin miscompares++;
      $display("FAIL reset_avm_read: got %b expected 00", {avm_read, avm_chipselect}); end
    vectors++; if (avm_address !== 11'h000) begin miscompares++;
      $display("FAIL reset_avm_address: got %h expected 000", avm_address); end
    vectors++; if ({out_valid, out_last, busy, done, err} !== 5'b00000) begin miscompares++;
      $display("FAIL reset_flags: got %b expected 00000", {out_valid, out_last, busy, done, err}); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++;
      $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    vectors++; if (avm_byteenable !== 2'b11) begin miscompares++;
      $display("FAIL byteenable: got %b expected 11", avm_byteenable); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int h;
    clear_logs(); lat = 1; ready_en = 1'b1;
    issue(11'h010, 12'd4, 11'd1, h);
    vectors++; if ({busy, cmd_ready} !== 2'b10) begin miscompares++;
      $display("FAIL basic_busy_ready: got %b expected 10", {busy, cmd_ready}); end
    wait_done(60);
    vectors++; if (done_cyc.size() != 1) begin miscompares++;
      $display("FAIL basic_done_count: got %0d expected 1", done_cyc.size()); end
    vectors++; if (acc_addrs.size() != 4) begin miscompares++;
      $display("FAIL basic_read_count: got %0d expected 4", acc_addrs.size()); end
    for (int i = 0; i < acc_addrs.size() && i < 4; i++) begin
      vectors++; if (acc_addrs[i] !== 11'(16 + i)) begin miscompares++;
        $display("FAIL basic_addr[%0d]: got %h expected %h", i, acc_addrs[i], 11'(16 + i)); end
      vectors++; if (acc_cyc[i] != h + 1 + i) begin miscompares++;
        $display("FAIL basic_issue_cycle[%0d]: got %0d expected %0d", i, acc_cyc[i], h + 1 + i);
      end
    end
    vectors++; if (got_data.size() != 4) begin miscompares++;
      $display("FAIL basic_word_count: got %0d expected 4", got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      vectors++; if (got_data[i] !== fdat(11'(16 + i))) begin miscompares++;
        $display("FAIL basic_data[%0d]: got %h expected %h", i, got_data[i], fdat(11'(16 + i)));
      end
      vectors++; if (got_last[i] !== (i == 3)) begin miscompares++;
        $display("FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
    end
    if (done_cyc.size() > 0 && got_cyc.size() == 4) begin
      vectors++; if (done_cyc[0] != got_cyc[3] + 1) begin miscompares++;
        $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc[0], got_cyc[3] + 1); end
    end
  endtask

  task automatic test_wrap();
    int h;
    logic [10:0] exp_a [4];
    exp_a[0] = 11'h7FE; exp_a[1] = 11'h7FF; exp_a[2] = 11'h000; exp_a[3] = 11'h001;
    clear_logs(); lat = 1; ready_en = 1'b1;
    issue(11'h7FE, 12'd4, 11'd1, h);
    wait_done(60);
    vectors++; if (acc_addrs.size() != 4 || got_data.size() != 4) begin miscompares++;
      $display("FAIL wrap_counts: got %0d/%0d expected 4/4", acc_addrs.size(), got_data.size());
    end
    for (int i = 0; i < acc_addrs.size() && i < 4; i++) begin
      vectors++; if (acc_addrs[i] !== exp_a[i]) begin miscompares++;
        $display("FAIL wrap_addr[%0d]: got %h expected %h", i, acc_addrs[i], exp_a[i]); end
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      vectors++; if (got_data[i] !== fdat(exp_a[i])) begin miscompares++;
        $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_data[i], fdat(exp_a[i])); end
    end
    vectors++; if (err !== 1'b0) begin miscompares++;
      $display("FAIL wrap_err: got %b expected 0", err); end
  endtask

  task automatic test_backpressure();
    int h;
    clear_logs(); lat = 1; ready_en = 1'b0;
    issue(11'h100, 12'd16, 11'd2, h);
    repeat (40) @(posedge clk);
    #1;
    vectors++; if (acc_addrs.size() != 8) begin miscompares++;
      $display("FAIL bp_reads_while_blocked: got %0d expected 8", acc_addrs.size()); end
    vectors++; if ({avm_read, out_valid, busy} !== 3'b011) begin miscompares++;
      $display("FAIL bp_stalled_flags: got %b expected 011", {avm_read, out_valid, busy}); end
    vectors++; if (out_data !== fdat(11'h100)) begin miscompares++;
      $display("FAIL bp_hold_data: got %h expected %h", out_data, fdat(11'h100)); end
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (out_data !== fdat(11'h100)) begin miscompares++;
      $display("FAIL bp_hold_data_later: got %h expected %h", out_data, fdat(11'h100)); end
    ready_en = 1'b1;
    wait_done(200);
    vectors++; if (done_cyc.size() != 1) begin miscompares++;
      $display("FAIL bp_done_count: got %0d expected 1", done_cyc.size()); end
    vectors++; if (acc_addrs.size() != 16 || got_data.size() != 16) begin miscompares++;
      $display("FAIL bp_counts: got %0d/%0d expected 16/16", acc_addrs.size(), got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 16; i++) begin
      vectors++; if (got_data[i] !== fdat(11'(256 + 2 * i))) begin miscompares++;
        $display("FAIL bp_data[%0d]: got %h expected %h", i, got_data[i], fdat(11'(256 + 2 * i)));
      end
      vectors++; if (got_last[i] !== (i == 15)) begin miscompares++;
        $display("FAIL bp_last[%0d]: got %b expected %b", i, got_last[i], (i == 15)); end
    end
  endtask

  task automatic test_stall();
    int h;
    clear_logs(); lat = 6; ready_en = 1'b1; stall_idx = 1; stall_len = 3;
    issue(11'h200, 12'd8, 11'd3, h);
    wait_done(200);
    vectors++; if (done_cyc.size() != 1) begin miscompares++;
      $display("FAIL stall_done_count: got %0d expected 1", done_cyc.size()); end
    vectors++; if (stall_seen !== 1'b1 || stable_bad != 0) begin miscompares++;
      $display("FAIL stall_hold: got seen=%b unstable=%0d expected seen=1 unstable=0",
               stall_seen, stable_bad); end
    vectors++; if (max_out > 4 || max_out < 1) begin miscompares++;
      $display("FAIL stall_max_pending: got %0d expected 1..4", max_out); end
    if (acc_cyc.size() >= 2) begin
      vectors++; if (acc_cyc[1] != acc_cyc[0] + 4) begin miscompares++;
        $display("FAIL stall_second_accept: got %0d expected %0d", acc_cyc[1], acc_cyc[0] + 4);
      end
    end
    vectors++; if (acc_addrs.size() != 8 || got_data.size() != 8) begin miscompares++;
      $display("FAIL stall_counts: got %0d/%0d expected 8/8", acc_addrs.size(), got_data.size());
    end
    for (int i = 0; i < acc_addrs.size() && i < 8; i++) begin
      vectors++; if (acc_addrs[i] !== 11'(512 + 3 * i)) begin miscompares++;
        $display("FAIL stall_addr[%0d]: got %h expected %h", i, acc_addrs[i], 11'(512 + 3 * i));
      end
    end
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      vectors++; if (got_data[i] !== fdat(11'(512 + 3 * i))) begin miscompares++;
        $display("FAIL stall_data[%0d]: got %h expected %h", i, got_data[i],
                 fdat(11'(512 + 3 * i))); end
    end
  endtask

  task automatic test_zero_len_err();
    int h;
    clear_logs(); lat = 1; ready_en = 1'b1;
    issue(11'h055, 12'd0, 11'd1, h);
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (acc_addrs.size() != 0) begin miscompares++;
      $display("FAIL zero_len_reads: got %0d expected 0", acc_addrs.size()); end
    vectors++; if (done_cyc.size() != 1) begin miscompares++;
      $display("FAIL zero_len_done_count: got %0d expected 1", done_cyc.size()); end
    if (done_cyc.size() > 0) begin
      vectors++; if (done_cyc[0] != h + 1) begin miscompares++;
        $display("FAIL zero_len_done_cycle: got %0d expected %0d", done_cyc[0], h + 1); end
    end
    vectors++; if (err !== 1'b0) begin miscompares++;
      $display("FAIL pre_spurious_err: got %b expected 0", err); end
    spur_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if ({err, out_valid, busy} !== 3'b100) begin miscompares++;
      $display("FAIL spurious_err: got %b expected 100", {err, out_valid, busy}); end
    repeat (6) @(posedge clk);
    #1;
    vectors++; if (err !== 1'b1) begin miscompares++;
      $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid();
    int h;
    clear_logs(); lat = 1; ready_en = 1'b1;
    issue(11'h300, 12'd10, 11'd1, h);
    repeat (3) @(posedge clk);
    #1;
    vectors++; if ({busy, avm_read, err} !== 3'b111) begin miscompares++;
      $display("FAIL mid_before_reset: got %b expected 111", {busy, avm_read, err}); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if ({cmd_ready, avm_read, avm_chipselect, out_valid, out_last, busy, done, err}
                   !== 8'b1000_0000) begin miscompares++;
      $display("FAIL mid_reset_flags: got %b expected 10000000",
               {cmd_ready, avm_read, avm_chipselect, out_valid, out_last, busy, done, err}); end
    vectors++; if ({avm_address, out_data} !== 27'h0) begin miscompares++;
      $display("FAIL mid_reset_buses: got %h/%h expected 000/0000", avm_address, out_data); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    issue(11'h020, 12'd2, 11'd1, h);
    wait_done(60);
    vectors++; if (done_cyc.size() != 1) begin miscompares++;
      $display("FAIL after_reset_done: got %0d expected 1", done_cyc.size()); end
    vectors++; if (acc_addrs.size() != 2 || got_data.size() != 2) begin miscompares++;
      $display("FAIL after_reset_counts: got %0d/%0d expected 2/2", acc_addrs.size(),
               got_data.size()); end
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      vectors++; if (got_data[i] !== fdat(11'(32 + i)) || got_last[i] !== (i == 1)) begin
        miscompares++;
        $display("FAIL after_reset_word[%0d]: got %h/%b expected %h/%b", i, got_data[i],
                 got_last[i], fdat(11'(32 + i)), (i == 1)); end
    end
    vectors++; if (err !== 1'b0) begin miscompares++;
      $display("FAIL after_reset_err: got %b expected 0", err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_stall();
    test_zero_len_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
